// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush clears to a NOP bubble, load captures a fetched
// instruction and its PC, otherwise the contents hold.
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = FETCH_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pcplus4,
    output logic            o_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_instr   <= XLEN'(NOP_INSTR);
            o_pc      <= '0;
            o_pcplus4 <= '0;
            o_valid   <= 1'b0;
        end else if (i_flush) begin
            o_instr   <= XLEN'(NOP_INSTR);
            o_valid   <= 1'b0;
        end else if (i_load) begin
            o_instr   <= i_instr;
            o_pc      <= i_pc;
            o_pcplus4 <= i_pc + XLEN'(4);
            o_valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem handshake and feeds IF/ID.
// Define FETCH_STATS_EN to add the stat_fetched / stat_stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_stall
`endif
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_pend, w_pend_nxt;
    logic [XLEN-1:0] r_hold, w_hold_nxt;
    logic [XLEN-1:0] r_hold_pc, w_hold_pc_nxt;
    logic [XLEN-1:0] w_target, w_pc_inc, w_ld_instr, w_ld_pc;
    logic            r_req, w_done, w_load, w_flush;

    assign w_target  = {redirect_target[XLEN-1:2], 2'b00};
    assign w_pc_inc  = r_pc + XLEN'(4);
    assign w_done    = r_req & imem_ready;
    assign imem_req  = r_req;
    // The address only moves on a completed transaction, so it is stable while pending.
    assign imem_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_pc      <= RESET_PC;
            r_pend    <= '0;
            r_hold    <= '0;
            r_hold_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= (w_state_nxt == FETCH) || (w_state_nxt == DISCARD);
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_hold    <= w_hold_nxt;
            r_hold_pc <= w_hold_pc_nxt;
        end
    end

    // Redirect takes priority over stall in every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_hold_nxt    = r_hold;
        w_hold_pc_nxt = r_hold_pc;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        w_ld_instr    = imem_rdata;
        w_ld_pc       = r_pc;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (redirect) begin
                    w_pc_nxt = w_target;
                    w_flush  = 1'b1;
                end
            end
            FETCH: begin
                if (redirect && w_done) begin
                    w_pc_nxt = w_target;
                    w_flush  = 1'b1;
                end else if (redirect) begin
                    w_pend_nxt  = w_target;
                    w_flush     = 1'b1;
                    w_state_nxt = DISCARD;
                end else if (w_done && stall) begin
                    w_hold_nxt    = imem_rdata;
                    w_hold_pc_nxt = r_pc;
                    w_pc_nxt      = w_pc_inc;
                    w_state_nxt   = HOLD;
                end else if (w_done) begin
                    w_load   = 1'b1;
                    w_pc_nxt = w_pc_inc;
                end else if (!stall) begin
                    w_flush = 1'b1;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    w_pend_nxt = w_target;
                    w_flush    = 1'b1;
                end
                if (w_done) begin
                    w_pc_nxt    = redirect ? w_target : r_pend;
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_target;
                    w_flush     = 1'b1;
                    w_state_nxt = FETCH;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_ld_instr  = r_hold;
                    w_ld_pc     = r_hold_pc;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    fetch_ifid_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_flush  (w_flush),
        .i_instr  (w_ld_instr),
        .i_pc     (w_ld_pc),
        .o_instr  (instr_d),
        .o_pc     (pc_d),
        .o_pcplus4(pcplus4_d),
        .o_valid  (valid_d)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched, r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_fetched <= '0;
            r_stat_stall   <= '0;
        end else begin
            r_stat_fetched <= r_stat_fetched + 32'(w_load);
            r_stat_stall   <= r_stat_stall + 32'(stall);
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] KEY    = 32'h1357_9BDF;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req, valid_d;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pcplus4_d;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory: each word is its address scrambled by a fixed key.
    assign imem_rdata = imem_addr ^ KEY;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d),
        .valid_d        (valid_d)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall)
`endif
    );

    // Reference model: next request address, a kill flag for an in-flight request
    // whose data must be dropped, a buffer of fetched-but-undelivered words, and IF/ID.
    bit          m_idle;
    bit          m_kill;
    logic [31:0] m_req_addr, m_after;
    logic [31:0] m_buf_pc[$];
    logic [31:0] m_if_pc;
    bit          m_valid;
    int unsigned m_fetched, m_stalls;

    function automatic bit m_exp_req();
        return !m_idle && (m_buf_pc.size() == 0);
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_kill = 1'b0;
        m_req_addr = RST_PC;
        m_after = '0;
        m_buf_pc.delete();
        m_if_pc = '0;
        m_valid = 1'b0;
        m_fetched = 0;
        m_stalls = 0;
    endtask

    task automatic model_step();
        bit          done;
        logic [31:0] tgt;
        done = m_exp_req() && imem_ready;
        tgt  = redirect_target & ~32'h3;
        if (m_idle) begin
            m_idle = 1'b0;
            if (redirect) begin
                m_req_addr = tgt;
                m_valid = 1'b0;
            end
        end else if (m_buf_pc.size() != 0) begin
            if (redirect) begin
                m_buf_pc.delete();
                m_req_addr = tgt;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_if_pc = m_buf_pc.pop_front();
                m_valid = 1'b1;
                m_fetched++;
            end
        end else if (redirect) begin
            m_valid = 1'b0;
            if (done) begin
                m_req_addr = tgt;
                m_kill = 1'b0;
            end else begin
                m_kill = 1'b1;
                m_after = tgt;
            end
        end else if (m_kill) begin
            if (done) begin
                m_req_addr = m_after;
                m_kill = 1'b0;
            end
        end else if (done) begin
            if (stall) m_buf_pc.push_back(m_req_addr);
            else begin
                m_if_pc = m_req_addr;
                m_valid = 1'b1;
                m_fetched++;
            end
            m_req_addr = m_req_addr + 32'd4;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
        if (stall) m_stalls++;
    endtask

    task automatic tick(input logic rdy, input logic st, input logic rd, input logic [31:0] tgt);
        imem_ready = rdy;
        stall = st;
        redirect = rd;
        redirect_target = tgt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (instr_d !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_d, NOP); end
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_d); end
        n_checks++; if (pc_d !== 32'h0 || pcplus4_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", pc_d, pcplus4_d); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_stream();
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL first_req: got %b/%h want 1/%h", imem_req, imem_addr, RST_PC); end
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            n_checks++; if (valid_d !== 1'b1 || pc_d !== RST_PC + 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc%0d: got %b/%h want 1/%h", k, valid_d, pc_d, RST_PC + 32'(4 * k)); end
            n_checks++; if (instr_d !== ((RST_PC + 32'(4 * k)) ^ KEY) || pcplus4_d !== RST_PC + 32'(4 * k + 4)) begin n_fail++; $display("FAIL stream_data%0d: got %h/%h", k, instr_d, pcplus4_d); end
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0008 || valid_d !== 1'b0) begin n_fail++; $display("FAIL wait%0d: got req %b addr %h valid %b want 1/bfc00008/0", k, imem_req, imem_addr, valid_d); end
        end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'hBFC0_0008) begin n_fail++; $display("FAIL wait_done: got %b/%h want 1/bfc00008", valid_d, pc_d); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            n_checks++; if (imem_req !== 1'b0 || valid_d !== 1'b1 || pc_d !== 32'hBFC0_0008) begin n_fail++; $display("FAIL stall_hold%0d: got req %b valid %b pc %h want 0/1/bfc00008", k, imem_req, valid_d, pc_d); end
        end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'hBFC0_000C || instr_d !== (32'hBFC0_000C ^ KEY)) begin n_fail++; $display("FAIL stall_release: got %b/%h/%h want held bfc0000c", valid_d, pc_d, instr_d); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC0_0010) begin n_fail++; $display("FAIL stall_next_req: got %b/%h want 1/bfc00010", imem_req, imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (pc_d !== 32'hBFC0_0010) begin n_fail++; $display("FAIL stall_next_pc: got %h want bfc00010", pc_d); end
    endtask

    task automatic test_redirect();
        tick(1'b1, 1'b0, 1'b1, 32'h100);
        n_checks++; if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect: got valid %b req %b addr %h want 0/1/100", valid_d, imem_req, imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h100) begin n_fail++; $display("FAIL redirect_pc: got %b/%h want 1/100", valid_d, pc_d); end
    endtask

    task automatic test_discard();
        tick(1'b0, 1'b0, 1'b1, 32'h203);
        n_checks++; if (valid_d !== 1'b0 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL discard_hold: got valid %b addr %h want 0/104", valid_d, imem_addr); end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b0, 1'b0, '0);
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL discard_wait%0d: got %b/%h want 1/104", k, imem_req, imem_addr); end
        end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL discard_drop: got valid %b req %b addr %h want 0/1/200", valid_d, imem_req, imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h200) begin n_fail++; $display("FAIL discard_target: got %b/%h want 1/200", valid_d, pc_d); end
    endtask

    task automatic test_hold_redirect();
        tick(1'b1, 1'b1, 1'b0, '0);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_req); end
        tick(1'b1, 1'b1, 1'b1, 32'h300);
        n_checks++; if (valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_fail++; $display("FAIL hold_redirect: got valid %b req %b addr %h want 0/1/300", valid_d, imem_req, imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h300) begin n_fail++; $display("FAIL hold_redirect_pc: got %b/%h want 1/300", valid_d, pc_d); end
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (pc_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got pc %h pc4 %h addr %h want fffffffc/0/0", pc_d, pcplus4_d, imem_addr); end
        tick(1'b1, 1'b0, 1'b0, '0);
        n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc_d); end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, '0);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", imem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || instr_d !== NOP || valid_d !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got req %b instr %h valid %b want 0/%h/0", imem_req, instr_d, valid_d, NOP); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 11) == 0), $urandom);
            n_checks++; if (imem_req !== m_exp_req()) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, m_exp_req()); end
            if (m_exp_req()) begin
                n_checks++; if (imem_addr !== m_req_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_req_addr); end
            end
            n_checks++; if (valid_d !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, valid_d, m_valid); end
            if (m_valid) begin
                n_checks++; if (pc_d !== m_if_pc || pcplus4_d !== m_if_pc + 32'd4 || instr_d !== (m_if_pc ^ KEY)) begin
                    n_fail++; $display("FAIL rnd_ifid@%0d: got %h/%h/%h want pc %h", i, pc_d, pcplus4_d, instr_d, m_if_pc);
                end
            end
        end
`ifdef FETCH_STATS_EN
        n_checks++; if (stat_fetched !== 32'(m_fetched) || stat_stall !== 32'(m_stalls)) begin
            n_fail++; $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_fetched, stat_stall, m_fetched, m_stalls);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_redirect();
        test_discard();
        test_hold_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
